// File: rtl/pocq_sched_pkg.sv
// ============================================================================
// Module      : pocq_pkg
// Description : Shared types, default sizes and TxnID-to-index mapping for the POCQ scheduler.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pocq_pkg;

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ISSUED = 2'd2,
      ST_SLEEP  = 2'd3
   } entry_state_e;

   localparam int C_DEPTH = 16;
   localparam int C_WIDTH = 8;

   // DEPTH is a power of two, so the modulo reduces to a mask.
   function automatic logic [7:0] txnid_to_idx(input logic [7:0] txnid, input int depth);
      return txnid & 8'(depth - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pocq_sched_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick of the first request at or after ptr_i.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int DEPTH = 16,
   parameter int IDXW  = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] req_i,
   input  logic [IDXW-1:0]  ptr_i,
   output logic [IDXW-1:0]  gnt_idx_o,
   output logic             gnt_valid_o
);

   logic [IDXW-1:0] w_idx;

   // Scan from the farthest offset back to ptr_i so the closest hit is written last.
   always_comb begin
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      w_idx       = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         w_idx = ptr_i + IDXW'(i);
         if (req_i[w_idx]) begin
            gnt_idx_o   = w_idx;
            gnt_valid_o = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/pocq_sched.sv
// ============================================================================
// Module      : pocq_sched
// Description : HN-F POCQ entry scheduler: per-TxnID lifecycle, payload store, round-robin issue.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pocq_sched
   import pocq_pkg::*;
#(
   parameter int WIDTH = C_WIDTH,
   parameter int DEPTH = C_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alloc_valid_i,
   input  logic [7:0]                 alloc_txnid_i,
   input  logic [WIDTH-1:0]           alloc_data_i,
   output logic                       alloc_ready_o,
   output logic                       iss_valid_o,
   input  logic                       iss_ready_i,
   output logic [$clog2(DEPTH)-1:0]   iss_txnid_o,
   output logic [WIDTH-1:0]           iss_data_o,
   input  logic                       retry_en_i,
   input  logic [7:0]                 retry_txnid_i,
   input  logic                       wake_en_i,
   input  logic [7:0]                 wake_txnid_i,
   input  logic                       done_en_i,
   input  logic [7:0]                 done_txnid_i,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       err_o
);

   localparam int IDXW = $clog2(DEPTH);
   localparam int CNTW = IDXW + 1;

   entry_state_e     state_q [DEPTH];
   logic [WIDTH-1:0] data_q  [DEPTH];
   logic [IDXW-1:0]  rr_q;
   logic [CNTW-1:0]  count_q, count_d;
   logic             err_q, err_d;

   logic [IDXW-1:0]  w_alloc_idx, w_retry_idx, w_wake_idx, w_done_idx, w_gnt_idx;
   logic [DEPTH-1:0] w_wait;
   logic             w_gnt_valid, w_alloc_fire, w_iss_fire, w_done_legal;

   assign w_alloc_idx = IDXW'(txnid_to_idx(alloc_txnid_i, DEPTH));
   assign w_retry_idx = IDXW'(txnid_to_idx(retry_txnid_i, DEPTH));
   assign w_wake_idx  = IDXW'(txnid_to_idx(wake_txnid_i, DEPTH));
   assign w_done_idx  = IDXW'(txnid_to_idx(done_txnid_i, DEPTH));

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_req
         assign w_wait[g] = (state_q[g] == ST_WAIT);
      end
   endgenerate

   rr_arbiter #(.DEPTH(DEPTH), .IDXW(IDXW)) u_arb (
      .req_i       (w_wait),
      .ptr_i       (rr_q),
      .gnt_idx_o   (w_gnt_idx),
      .gnt_valid_o (w_gnt_valid)
   );

   assign alloc_ready_o = (state_q[w_alloc_idx] == ST_FREE);
   assign iss_valid_o   = w_gnt_valid;
   assign iss_txnid_o   = w_gnt_idx;
   assign iss_data_o    = data_q[w_gnt_idx];
   assign w_alloc_fire  = alloc_valid_i && alloc_ready_o;
   assign w_iss_fire    = w_gnt_valid && iss_ready_i;

   assign count_o = count_q;
   assign full_o  = (count_q == CNTW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign err_o   = err_q;

   // A retry that coincides with a legal done on the same entry is absorbed by the done.
   always_comb begin
      w_done_legal = done_en_i && ((state_q[w_done_idx] == ST_ISSUED) ||
                                   (state_q[w_done_idx] == ST_SLEEP));
      err_d = err_q
            | (retry_en_i && (state_q[w_retry_idx] != ST_ISSUED) &&
               !(w_done_legal && (w_done_idx == w_retry_idx)))
            | (wake_en_i && (state_q[w_wake_idx] != ST_SLEEP))
            | (done_en_i && !w_done_legal);
      count_d = count_q + CNTW'(w_alloc_fire) - CNTW'(w_done_legal);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_FREE;
         rr_q    <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            case (state_q[i])
               ST_FREE:
                  if (w_alloc_fire && (w_alloc_idx == IDXW'(i))) state_q[i] <= ST_WAIT;
               ST_WAIT:
                  if (w_iss_fire && (w_gnt_idx == IDXW'(i))) state_q[i] <= ST_ISSUED;
               ST_ISSUED:
                  if (done_en_i && (w_done_idx == IDXW'(i)))        state_q[i] <= ST_FREE;
                  else if (retry_en_i && (w_retry_idx == IDXW'(i))) state_q[i] <= ST_SLEEP;
               ST_SLEEP:
                  if (done_en_i && (w_done_idx == IDXW'(i)))      state_q[i] <= ST_FREE;
                  else if (wake_en_i && (w_wake_idx == IDXW'(i))) state_q[i] <= ST_WAIT;
               default: state_q[i] <= ST_FREE;
            endcase
         end
         if (w_iss_fire) rr_q <= w_gnt_idx + IDXW'(1);
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_alloc_fire) data_q[w_alloc_idx] <= alloc_data_i;
   end

endmodule

`default_nettype wire

// File: tb/tb_pocq_sched.sv
// ============================================================================
// Module      : tb_pocq_sched
// Description : Directed scoreboard bench for pocq_sched.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pocq_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       alloc_valid_i = 1'b0;
   logic [7:0] alloc_txnid_i = '0;
   logic [7:0] alloc_data_i  = '0;
   logic       alloc_ready_o;
   logic       iss_valid_o;
   logic       iss_ready_i = 1'b0;
   logic [3:0] iss_txnid_o;
   logic [7:0] iss_data_o;
   logic       retry_en_i = 1'b0;
   logic [7:0] retry_txnid_i = '0;
   logic       wake_en_i = 1'b0;
   logic [7:0] wake_txnid_i = '0;
   logic       done_en_i = 1'b0;
   logic [7:0] done_txnid_i = '0;
   logic [4:0] count_o;
   logic       full_o, empty_o, err_o;

   pocq_sched #(.WIDTH(8), .DEPTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .alloc_valid_i (alloc_valid_i),
      .alloc_txnid_i (alloc_txnid_i),
      .alloc_data_i  (alloc_data_i),
      .alloc_ready_o (alloc_ready_o),
      .iss_valid_o   (iss_valid_o),
      .iss_ready_i   (iss_ready_i),
      .iss_txnid_o   (iss_txnid_o),
      .iss_data_o    (iss_data_o),
      .retry_en_i    (retry_en_i),
      .retry_txnid_i (retry_txnid_i),
      .wake_en_i     (wake_en_i),
      .wake_txnid_i  (wake_txnid_i),
      .done_en_i     (done_en_i),
      .done_txnid_i  (done_txnid_i),
      .count_o       (count_o),
      .full_o        (full_o),
      .empty_o       (empty_o),
      .err_o         (err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic expect_issue(input int id, input int d);
      exp_t e;
      e.id   = 4'(id);
      e.data = 8'(d);
      sb_q.push_back(e);
   endtask

   // Every handshake must match the next queued expectation.
   always @(negedge clk) begin
      if (!rst && iss_valid_o && iss_ready_i) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_issue: got txnid %0d data %0h, expected none",
                     iss_txnid_o, iss_data_o);
         end else begin
            mon_e = sb_q.pop_front();
            if (iss_txnid_o !== mon_e.id || iss_data_o !== mon_e.data) begin
               n_fail++;
               $display("FAIL issue_order: got txnid %0d data %0h expected txnid %0d data %0h",
                        iss_txnid_o, iss_data_o, mon_e.id, mon_e.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_valid_i = 1'b0;
      retry_en_i    = 1'b0;
      wake_en_i     = 1'b0;
      done_en_i     = 1'b0;
   endtask

   task automatic alloc(input int txn, input int d);
      alloc_valid_i = 1'b1;
      alloc_txnid_i = 8'(txn);
      alloc_data_i  = 8'(d);
   endtask

   task automatic done(input int txn);
      done_en_i    = 1'b1;
      done_txnid_i = 8'(txn);
      step();
      done_en_i    = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      step();
      step();
      rst = 1'b0;
      alloc_txnid_i = 8'd0;
      check("rst_count", count_o, 0);
      check("rst_empty", empty_o, 1);
      check("rst_full", full_o, 0);
      check("rst_iss_valid", iss_valid_o, 0);
      check("rst_err", err_o, 0);
      check("rst_alloc_ready", alloc_ready_o, 1);

      // Back-to-back allocs issue in order.
      iss_ready_i = 1'b1;
      alloc(3, 8'hA3); expect_issue(3, 8'hA3); step();
      alloc(5, 8'hA5); expect_issue(5, 8'hA5); step();
      alloc(9, 8'hA9); expect_issue(9, 8'hA9); step();
      idle();
      check("t1_count_peak", count_o, 3);
      step();
      check("t1_count_after", count_o, 3);
      check("t1_rr", dut.rr_q, 10);
      done(3); done(5); done(9);
      check("t1_count_drain", count_o, 0);

      // Fill all entries, then free index 4 and re-use it via TxnID 20.
      for (int i = 0; i < 16; i++) begin
         alloc(i, 8'h40 + i);
         expect_issue(i, 8'h40 + i);
         step();
      end
      idle();
      step();
      check("t2_full", full_o, 1);
      check("t2_count16", count_o, 16);
      alloc(20, 8'h99);
      done_en_i    = 1'b1;
      done_txnid_i = 8'd4;
      check("t2_ready_full", alloc_ready_o, 0);
      step();
      done_en_i = 1'b0;
      check("t2_ready_after_done", alloc_ready_o, 1);
      check("t2_count15", count_o, 15);
      expect_issue(4, 8'h99);
      step();
      idle();
      check("t2_count_refill", count_o, 16);
      step();
      for (int i = 0; i < 16; i++) done(i);
      check("t2_empty", empty_o, 1);
      check("t2_err", err_o, 0);

      // Retry puts 7 to sleep; wake re-offers it with the original payload.
      alloc(7, 8'h77); expect_issue(7, 8'h77); step();
      idle();
      step();
      retry_en_i = 1'b1; retry_txnid_i = 8'd7; step();
      retry_en_i = 1'b0;
      check("t3_sleep_no_offer", iss_valid_o, 0);
      step();
      check("t3_sleep_no_offer2", iss_valid_o, 0);
      wake_en_i = 1'b1; wake_txnid_i = 8'd7; expect_issue(7, 8'h77); step();
      wake_en_i = 1'b0;
      check("t3_wake_valid", iss_valid_o, 1);
      check("t3_wake_txnid", iss_txnid_o, 7);
      check("t3_wake_data", iss_data_o, 8'h77);
      step();
      done(7);

      // Back-pressure holds grant and payload stable.
      iss_ready_i = 1'b0;
      alloc(2, 8'h22); step();
      alloc(6, 8'h66); step();
      idle();
      expect_issue(2, 8'h22);
      expect_issue(6, 8'h66);
      for (int k = 0; k < 4; k++) begin
         check("t4_hold_txnid", iss_txnid_o, 2);
         check("t4_hold_data", iss_data_o, 8'h22);
         step();
      end
      iss_ready_i = 1'b1;
      step();
      check("t4_next_txnid", iss_txnid_o, 6);
      step();
      done(2); done(6);

      // Illegal events set err without changing state.
      wake_en_i = 1'b1; wake_txnid_i = 8'd10; step();
      idle();
      check("t5_wake_free_err", err_o, 1);
      check("t5_wake_free_count", count_o, 0);
      check("t5_wake_free_valid", iss_valid_o, 0);
      do_reset();
      check("t5_err_cleared", err_o, 0);
      iss_ready_i = 1'b0;
      alloc(11, 8'hBB); step();
      idle();
      done(11);
      check("t5_done_wait_err", err_o, 1);
      check("t5_done_wait_count", count_o, 1);
      check("t5_done_wait_txnid", iss_txnid_o, 11);
      do_reset();
      iss_ready_i = 1'b1;
      alloc(1, 8'h11); expect_issue(1, 8'h11); step();
      idle();
      step();
      retry_en_i = 1'b1; retry_txnid_i = 8'd1;
      done_en_i  = 1'b1; done_txnid_i  = 8'd1;
      step();
      idle();
      alloc_txnid_i = 8'd1;
      check("t5_retry_done_err", err_o, 0);
      check("t5_retry_done_count", count_o, 0);
      check("t5_retry_done_free", alloc_ready_o, 1);

      // Reset with entries in mixed states.
      for (int i = 0; i < 5; i++) begin
         alloc(i, 8'h50 + i);
         if (i < 4) expect_issue(i, 8'h50 + i);
         step();
      end
      idle();
      iss_ready_i = 1'b0;
      retry_en_i = 1'b1; retry_txnid_i = 8'd1; step();
      idle();
      check("t6_pre_count", count_o, 5);
      rst = 1'b1;
      alloc(8, 8'hEE);
      done_en_i = 1'b1; done_txnid_i = 8'd0;
      step();
      rst = 1'b0;
      idle();
      alloc_txnid_i = 8'd0;
      check("t6_count", count_o, 0);
      check("t6_empty", empty_o, 1);
      check("t6_full", full_o, 0);
      check("t6_iss_valid", iss_valid_o, 0);
      check("t6_err", err_o, 0);
      check("t6_rr", dut.rr_q, 0);
      check("t6_alloc_ready", alloc_ready_o, 1);
      iss_ready_i = 1'b1;
      alloc(0, 8'h5A); expect_issue(0, 8'h5A); step();
      idle();
      step();
      done(0);
      check("t6_final_count", count_o, 0);

      step();
      check("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
